vga_plot_queue: RTL and testbench
=================================

# vga_plot_queue

Elastic buffer between the drawing engines (fill-screen, circle, triangle) and the VGA adapter's pixel-write port. Accepts one plot request per cycle, discards off-screen coordinates, queues valid pixels in a small FIFO and presents them one at a time on registered `vga_*` outputs. The engine advances freely while the adapter, or a future arbiter, applies back-pressure through `out_ready`.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `X_MAX`, 160: first illegal x.
- `Y_MAX`, 120: first illegal y.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_x` in 8: request x.
- `in_y` in 7: request y.
- `in_colour` in 3: request colour.
- `in_plot` in 1: request valid this cycle.
- `clear` in 1: synchronous flush.
- `out_ready` in 1: downstream accepts the presented pixel this cycle.
- `in_full` out 1: FIFO holds `DEPTH` entries.
- `empty` out 1: FIFO empty and no pixel presented.
- `vga_x` out 8: presented x.
- `vga_y` out 7: presented y.
- `vga_colour` out 3: presented colour.
- `vga_plot` out 1: presented pixel valid.
- `drop_count` out 8: saturating count of discarded requests.

## Operation
- **Accept.** Push when `in_plot` & `in_x < X_MAX` & `in_y < Y_MAX` & !`in_full`.
- **Drop, off-screen.** `in_plot` with an out-of-range coordinate increments `drop_count`; no push.
- **Drop, overflow.** `in_plot` in range while `in_full` increments `drop_count`.
  - `in_full` is evaluated on the registered occupancy. A same-cycle pop does not rescue the request.
- **`drop_count` width.** Saturates at 255 and never wraps.
- **Output register.** Holds one pixel.
  - Load from the FIFO head when (!`vga_plot` | `out_ready`) & FIFO non-empty.
  - If that condition holds with the FIFO empty, `vga_plot` falls to 0.
  - While `vga_plot` & !`out_ready`, `vga_x/y/colour` and `vga_plot` hold stable.
- **Occupancy.** FIFO occupancy counter is `$clog2(DEPTH)+1` bits wide and excludes the output register.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Read and write pointers wrap modulo `DEPTH`.
- **`clear`.** Empties the FIFO, drops `vga_plot` and zeroes `drop_count` at the next edge.
  - `clear` takes priority over a simultaneous push or pop. A request in the `clear` cycle is neither stored nor counted.
- **`empty`.** Equals (occupancy == 0) & !`vga_plot`. Engines use it to know all pixels have been handed off before asserting their own `done`.

## Timing
- **Reset values.** All outputs 0 except `empty` = 1. Pointers and occupancy are 0.
- **Reset mid-operation.** Reset asserted mid-stream discards all queued pixels immediately; no partial pixel is emitted.
- **Latency.** With the queue idle, a request accepted at edge N appears with `vga_plot` = 1 after edge N+1: 2-cycle latency.
- **Throughput.** With `out_ready` held at 1, one pixel per cycle is sustained indefinitely.
- **Status outputs.** `in_full` and `empty` are registered-state decodes with no combinational path from inputs.
- **Output handshake.** A presented pixel is consumed in the cycle where `vga_plot` & `out_ready`. The next head appears after that same edge.

## Structure
- Package `vga_pkg`:
  - `SCREEN_W` = 160 and `SCREEN_H` = 120, used as the `X_MAX`/`Y_MAX` defaults.
  - Typedef `pixel_t` as a packed struct {x[7:0], y[6:0], colour[2:0]}.
- Sub-module `pixel_fifo`: generic `DEPTH`×`pixel_t` storage holding pointers, occupancy, push/pop and flush.
- Top level holds the clip check, the drop counter and the output register.

## Test plan
- **Single pixel.** Reset, then one request (10,20,3'b101) with `out_ready` = 1.
  - `vga_plot` = 1 with (10,20,5) two edges later for one cycle.
  - `empty` returns to 1 the following cycle.
- **Clipping.** Requests (159,119), (160,0), (0,120), all with `out_ready` = 1.
  - Only (159,119) is emitted.
  - `drop_count` = 2.
- **Back-pressure and overflow.** `out_ready` = 0; issue 12 in-range requests on consecutive cycles.
  - One pixel sits in the output register and 8 are queued; `in_full` = 1; `drop_count` = 3.
  - Then raise `out_ready`: 9 pixels emerge in order on consecutive cycles.
- **Stall hold.** With `vga_plot` = 1 and `out_ready` = 0 for 5 cycles, `vga_x/y/colour` stay unchanged.
  - The first cycle with `out_ready` = 1 advances to the next pixel.
- **Clear with saturation.** Push 300 off-screen requests, then 4 valid ones, then assert `clear` together with a valid request.
  - `drop_count` reaches 255 and holds.
  - After `clear`: `vga_plot` = 0, `empty` = 1, `drop_count` = 0.
- **Asynchronous reset.** Assert `rst` mid-drain between clock edges.
  - Outputs drop to reset values immediately, without waiting for an edge.
  - After release, a new request emerges with the 2-cycle latency.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry and pixel record shared by the plot path
package vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: DEPTH-entry pixel FIFO with occupancy count and synchronous flush
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  pixel_t wr_data,
  output pixel_t rd_data,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  pixel_t mem [DEPTH];
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & !full & !flush;
  assign do_pop = pop & !empty & !flush;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/vga_plot_queue.sv
// vga_plot_queue: clips plot requests, queues them and presents one pixel at a time to the VGA adapter
module vga_plot_queue
  import vga_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int X_MAX = SCREEN_W,
  parameter int Y_MAX = SCREEN_H
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  input  logic       in_plot,
  input  logic       clear,
  input  logic       out_ready,
  output logic       in_full,
  output logic       empty,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [7:0] drop_count
);
  logic in_range, push, drop, advance, fifo_empty;
  pixel_t head;
  assign in_range = (32'(in_x) < X_MAX) & (32'(in_y) < Y_MAX);
  assign push = in_plot & in_range & !in_full & !clear;
  assign drop = in_plot & !(in_range & !in_full);
  assign advance = !vga_plot | out_ready;
  assign empty = fifo_empty & !vga_plot;
  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(advance),
    .flush(clear),
    .wr_data({in_x, in_y, in_colour}),
    .rd_data(head),
    .full(in_full),
    .empty(fifo_empty)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      vga_plot <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      vga_plot <= 1'b0;
      drop_count <= '0;
    end else begin
      if (advance) begin
        vga_plot <= !fifo_empty;
        if (!fifo_empty) {vga_x, vga_y, vga_colour} <= head;
      end
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_vga_plot_queue.sv
// tb_vga_plot_queue: randomized and directed checks against a queue-based reference model
module tb_vga_plot_queue;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1;
  logic [7:0] in_x = 0;
  logic [6:0] in_y = 0;
  logic [2:0] in_colour = 0;
  logic in_plot = 0, clear = 0, out_ready = 0;
  logic in_full, empty, vga_plot;
  logic [7:0] vga_x, drop_count;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  int tests = 0, fails = 0;

  vga_plot_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .in_plot(in_plot), .clear(clear), .out_ready(out_ready), .in_full(in_full),
    .empty(empty), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference: pending pixels as a plain queue, one presented slot, a saturating drop tally
  logic [17:0] q[$];
  bit pv = 0;
  logic [17:0] pix = 0;
  int dc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); pv = 0; dc = 0;
    end else if (clear) begin
      q.delete(); pv = 0; dc = 0;
    end else begin : step
      bit full, ok;
      full = q.size() == DEPTH;
      ok = in_x < 160 && in_y < 120;
      if (!pv || out_ready) begin
        pv = q.size() > 0;
        if (pv) pix = q.pop_front();
      end
      if (in_plot && ok && !full) q.push_back({in_x, in_y, in_colour});
      else if (in_plot && dc < 255) dc++;
    end
  end

  always @(negedge clk) begin
    chk("plot", vga_plot, pv);
    chk("in_full", in_full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0 && !pv);
    chk("drop_count", drop_count, dc);
    if (pv) chk("pixel", {vga_x, vga_y, vga_colour}, pix);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int x, input int y, input int c);
    in_plot = 1; in_x = 8'(x); in_y = 7'(y); in_colour = 3'(c);
  endtask

  int seen;
  logic [17:0] got, held;

  initial begin
    #3;
    chk("rst_plot", vga_plot, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", in_full, 0);
    chk("rst_drops", drop_count, 0);
    #20 rst = 0;
    // single pixel
    out_ready = 1;
    set_req(10, 20, 5);
    tick();
    in_plot = 0;
    tick();
    chk("single_plot", vga_plot, 1);
    chk("single_pix", {vga_x, vga_y, vga_colour}, {8'd10, 7'd20, 3'd5});
    tick();
    chk("single_done", vga_plot, 0);
    chk("single_empty", empty, 1);
    // clipping
    seen = 0; got = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) set_req(159, 119, 2);
      else if (i == 1) set_req(160, 0, 2);
      else if (i == 2) set_req(0, 120, 2);
      else in_plot = 0;
      tick();
      if (vga_plot) begin seen++; got = {vga_x, vga_y, vga_colour}; end
    end
    chk("clip_count", seen, 1);
    chk("clip_pix", got, {8'd159, 7'd119, 3'd2});
    chk("clip_drops", drop_count, 2);
    // back-pressure and overflow
    clear = 1; tick(); clear = 0;
    out_ready = 0;
    for (int i = 0; i < 12; i++) begin set_req(i + 1, i + 2, i); tick(); end
    in_plot = 0;
    tick();
    chk("bp_full", in_full, 1);
    chk("bp_drops", drop_count, 3);
    chk("bp_head", vga_x, 1);
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("bp_plot", vga_plot, 1);
      chk("bp_order", {vga_x, vga_y}, {8'(k + 1), 7'(k + 2)});
    end
    tick();
    chk("bp_drained", vga_plot, 0);
    // stall hold
    out_ready = 0;
    set_req(50, 51, 1); tick();
    set_req(60, 61, 2); tick();
    set_req(70, 71, 3); tick();
    in_plot = 0;
    held = {vga_x, vga_y, vga_colour};
    chk("stall_first", held, {8'd50, 7'd51, 3'd1});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", {vga_plot, vga_x, vga_y, vga_colour}, {1'b1, held});
    end
    out_ready = 1;
    tick();
    chk("stall_next", {vga_x, vga_y, vga_colour}, {8'd60, 7'd61, 3'd2});
    repeat (4) tick();
    // saturation and clear
    for (int i = 0; i < 300; i++) begin set_req(200, 0, 0); tick(); end
    chk("sat_drops", drop_count, 255);
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin set_req(i, i, i); tick(); end
    set_req(5, 5, 5); clear = 1;
    tick();
    clear = 0; in_plot = 0;
    chk("clr_plot", vga_plot, 0);
    chk("clr_empty", empty, 1);
    chk("clr_drops", drop_count, 0);
    tick();
    chk("clr_not_stored", empty, 1);
    // asynchronous reset mid-drain
    for (int i = 0; i < 5; i++) begin set_req(30 + i, 40, i); tick(); end
    set_req(0, 127, 0); tick();
    in_plot = 0; out_ready = 1;
    tick();
    #3 rst = 1;
    #1;
    chk("arst_plot", vga_plot, 0);
    chk("arst_empty", empty, 1);
    chk("arst_drops", drop_count, 0);
    chk("arst_x", vga_x, 0);
    #1 rst = 0;
    set_req(77, 66, 6);
    tick();
    in_plot = 0;
    chk("arst_lat1", vga_plot, 0);
    tick();
    chk("arst_lat2", {vga_plot, vga_x, vga_y, vga_colour}, {1'b1, 8'd77, 7'd66, 3'd6});
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_plot = $urandom_range(0, 9) < 7;
      in_x = 8'($urandom_range(0, 180));
      in_y = 7'($urandom_range(0, 127));
      in_colour = 3'($urandom);
      out_ready = (i / 64) % 2 == 0 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0;
      clear = $urandom_range(0, 99) == 0;
      tick();
    end
    in_plot = 0; clear = 0; out_ready = 1;
    repeat (12) tick();
    chk("final_empty", empty, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
